instr_encoder: RTL and testbench

Assembles MIPS instruction words from a mnemonic code plus register and immediate fields. It is the encoder counterpart of the pipeline's instruction decoder. Encoded words are buffered and streamed with ready/valid and a running word address, to the instruction-memory loader and to the test benches. It covers the full instruction set the D-stage decoder recognises.

---
 rtl/instr_encoder_pkg.sv | 147 ++++++++++++++
 rtl/instr_encoder_sync_fifo.sv | 45 ++++
 rtl/instr_encoder.sv | 110 +++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: mnemonic codes (6-bit,
// nop = 0), opcode/funct constants matching the D-stage decoder, mnemonic
// classification, FSM state codes and the word-assembly function.
package instr_encoder_pkg;

    // Mnemonic codes presented on in_op; 51..63 are illegal
    localparam logic [5:0]
        M_NOP   = 6'd0,  M_ADD   = 6'd1,  M_ADDU  = 6'd2,  M_SUB   = 6'd3,
        M_SUBU  = 6'd4,  M_AND   = 6'd5,  M_OR    = 6'd6,  M_XOR   = 6'd7,
        M_NOR   = 6'd8,  M_SLT   = 6'd9,  M_SLTU  = 6'd10, M_SLLV  = 6'd11,
        M_SRLV  = 6'd12, M_SRAV  = 6'd13, M_SLL   = 6'd14, M_SRL   = 6'd15,
        M_SRA   = 6'd16, M_MULT  = 6'd17, M_MULTU = 6'd18, M_DIV   = 6'd19,
        M_DIVU  = 6'd20, M_MFHI  = 6'd21, M_MFLO  = 6'd22, M_MTHI  = 6'd23,
        M_MTLO  = 6'd24, M_JR    = 6'd25, M_JALR  = 6'd26, M_ADDI  = 6'd27,
        M_ADDIU = 6'd28, M_ANDI  = 6'd29, M_ORI   = 6'd30, M_XORI  = 6'd31,
        M_SLTI  = 6'd32, M_SLTIU = 6'd33, M_LB    = 6'd34, M_LBU   = 6'd35,
        M_LH    = 6'd36, M_LHU   = 6'd37, M_LW    = 6'd38, M_SB    = 6'd39,
        M_SH    = 6'd40, M_SW    = 6'd41, M_BEQ   = 6'd42, M_BNE   = 6'd43,
        M_LUI   = 6'd44, M_BLEZ  = 6'd45, M_BGTZ  = 6'd46, M_BLTZ  = 6'd47,
        M_BGEZ  = 6'd48, M_J     = 6'd49, M_JAL   = 6'd50;

    // Primary opcodes
    localparam logic [5:0]
        OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J    = 6'h02, OPC_JAL   = 6'h03,
        OPC_BEQ     = 6'h04, OPC_BNE    = 6'h05, OPC_BLEZ = 6'h06, OPC_BGTZ  = 6'h07,
        OPC_ADDI    = 6'h08, OPC_ADDIU  = 6'h09, OPC_SLTI = 6'h0A, OPC_SLTIU = 6'h0B,
        OPC_ANDI    = 6'h0C, OPC_ORI    = 6'h0D, OPC_XORI = 6'h0E, OPC_LUI   = 6'h0F,
        OPC_LB      = 6'h20, OPC_LH     = 6'h21, OPC_LW   = 6'h23, OPC_LBU   = 6'h24,
        OPC_LHU     = 6'h25, OPC_SB     = 6'h28, OPC_SH   = 6'h29, OPC_SW    = 6'h2B;

    // SPECIAL funct codes; RT_* are the REGIMM rt selectors
    localparam logic [5:0]
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_SLLV = 6'h04,
        FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR    = 6'h08, FN_JALR = 6'h09,
        FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO  = 6'h12, FN_MTLO = 6'h13,
        FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B,
        FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23,
        FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR   = 6'h26, FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A, FN_SLTU = 6'h2B, RT_BLTZ  = 6'h00, RT_BGEZ = 6'h01;

    // FSM state codes
    localparam logic [0:0] ST_IDLE = 1'b0, ST_PAD = 1'b1;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_RALU, CLS_SHIFT, CLS_MULDIV, CLS_MFHL, CLS_MTHL, CLS_JALR,
        CLS_ITYPE, CLS_LUI, CLS_BZ, CLS_REGIMM, CLS_JUMP, CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        op_class_t  cls;
        logic [5:0] opcode;
        logic [5:0] funct;   // REGIMM: low 5 bits carry the rt selector
    } mnem_info_t;

    function automatic mnem_info_t mnem_info(input logic [5:0] op);
        mnem_info_t m;
        m = '{CLS_ILLEGAL, 6'd0, 6'd0};
        case (op)
            M_NOP:   m = '{CLS_NOP,    OPC_SPECIAL, 6'd0};
            M_ADD:   m = '{CLS_RALU,   OPC_SPECIAL, FN_ADD};
            M_ADDU:  m = '{CLS_RALU,   OPC_SPECIAL, FN_ADDU};
            M_SUB:   m = '{CLS_RALU,   OPC_SPECIAL, FN_SUB};
            M_SUBU:  m = '{CLS_RALU,   OPC_SPECIAL, FN_SUBU};
            M_AND:   m = '{CLS_RALU,   OPC_SPECIAL, FN_AND};
            M_OR:    m = '{CLS_RALU,   OPC_SPECIAL, FN_OR};
            M_XOR:   m = '{CLS_RALU,   OPC_SPECIAL, FN_XOR};
            M_NOR:   m = '{CLS_RALU,   OPC_SPECIAL, FN_NOR};
            M_SLT:   m = '{CLS_RALU,   OPC_SPECIAL, FN_SLT};
            M_SLTU:  m = '{CLS_RALU,   OPC_SPECIAL, FN_SLTU};
            M_SLLV:  m = '{CLS_RALU,   OPC_SPECIAL, FN_SLLV};
            M_SRLV:  m = '{CLS_RALU,   OPC_SPECIAL, FN_SRLV};
            M_SRAV:  m = '{CLS_RALU,   OPC_SPECIAL, FN_SRAV};
            M_SLL:   m = '{CLS_SHIFT,  OPC_SPECIAL, FN_SLL};
            M_SRL:   m = '{CLS_SHIFT,  OPC_SPECIAL, FN_SRL};
            M_SRA:   m = '{CLS_SHIFT,  OPC_SPECIAL, FN_SRA};
            M_MULT:  m = '{CLS_MULDIV, OPC_SPECIAL, FN_MULT};
            M_MULTU: m = '{CLS_MULDIV, OPC_SPECIAL, FN_MULTU};
            M_DIV:   m = '{CLS_MULDIV, OPC_SPECIAL, FN_DIV};
            M_DIVU:  m = '{CLS_MULDIV, OPC_SPECIAL, FN_DIVU};
            M_MFHI:  m = '{CLS_MFHL,   OPC_SPECIAL, FN_MFHI};
            M_MFLO:  m = '{CLS_MFHL,   OPC_SPECIAL, FN_MFLO};
            M_MTHI:  m = '{CLS_MTHL,   OPC_SPECIAL, FN_MTHI};
            M_MTLO:  m = '{CLS_MTHL,   OPC_SPECIAL, FN_MTLO};
            M_JR:    m = '{CLS_MTHL,   OPC_SPECIAL, FN_JR};
            M_JALR:  m = '{CLS_JALR,   OPC_SPECIAL, FN_JALR};
            M_ADDI:  m = '{CLS_ITYPE,  OPC_ADDI,    6'd0};
            M_ADDIU: m = '{CLS_ITYPE,  OPC_ADDIU,   6'd0};
            M_ANDI:  m = '{CLS_ITYPE,  OPC_ANDI,    6'd0};
            M_ORI:   m = '{CLS_ITYPE,  OPC_ORI,     6'd0};
            M_XORI:  m = '{CLS_ITYPE,  OPC_XORI,    6'd0};
            M_SLTI:  m = '{CLS_ITYPE,  OPC_SLTI,    6'd0};
            M_SLTIU: m = '{CLS_ITYPE,  OPC_SLTIU,   6'd0};
            M_LB:    m = '{CLS_ITYPE,  OPC_LB,      6'd0};
            M_LBU:   m = '{CLS_ITYPE,  OPC_LBU,     6'd0};
            M_LH:    m = '{CLS_ITYPE,  OPC_LH,      6'd0};
            M_LHU:   m = '{CLS_ITYPE,  OPC_LHU,     6'd0};
            M_LW:    m = '{CLS_ITYPE,  OPC_LW,      6'd0};
            M_SB:    m = '{CLS_ITYPE,  OPC_SB,      6'd0};
            M_SH:    m = '{CLS_ITYPE,  OPC_SH,      6'd0};
            M_SW:    m = '{CLS_ITYPE,  OPC_SW,      6'd0};
            M_BEQ:   m = '{CLS_ITYPE,  OPC_BEQ,     6'd0};
            M_BNE:   m = '{CLS_ITYPE,  OPC_BNE,     6'd0};
            M_LUI:   m = '{CLS_LUI,    OPC_LUI,     6'd0};
            M_BLEZ:  m = '{CLS_BZ,     OPC_BLEZ,    6'd0};
            M_BGTZ:  m = '{CLS_BZ,     OPC_BGTZ,    6'd0};
            M_BLTZ:  m = '{CLS_REGIMM, OPC_REGIMM,  RT_BLTZ};
            M_BGEZ:  m = '{CLS_REGIMM, OPC_REGIMM,  RT_BGEZ};
            M_J:     m = '{CLS_JUMP,   OPC_J,       6'd0};
            M_JAL:   m = '{CLS_JUMP,   OPC_JAL,     6'd0};
            default: m = '{CLS_ILLEGAL, 6'd0, 6'd0};
        endcase
        return m;
    endfunction

    // Branches and jumps: followed by a delay-slot pad when that is enabled
    function automatic logic is_cti(input logic [5:0] op);
        case (op)
            M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_BGEZ,
            M_J, M_JAL, M_JR, M_JALR: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    // Fields a format does not use are forced to zero
    function automatic logic [31:0] encode(
        input mnem_info_t m, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [4:0] shamt,
        input logic [15:0] imm16, input logic [25:0] imm26);
        logic [4:0] link_rd;
        link_rd = (rd == 5'd0) ? 5'd31 : rd;
        case (m.cls)
            CLS_RALU:   return {OPC_SPECIAL, rs, rt, rd, 5'd0, m.funct};
            CLS_SHIFT:  return {OPC_SPECIAL, 5'd0, rt, rd, shamt, m.funct};
            CLS_MULDIV: return {OPC_SPECIAL, rs, rt, 10'd0, m.funct};
            CLS_MFHL:   return {16'd0, rd, 5'd0, m.funct};
            CLS_MTHL:   return {OPC_SPECIAL, rs, 15'd0, m.funct};
            CLS_JALR:   return {OPC_SPECIAL, rs, 5'd0, link_rd, 5'd0, m.funct};
            CLS_ITYPE:  return {m.opcode, rs, rt, imm16};
            CLS_LUI:    return {m.opcode, 5'd0, rt, imm16};
            CLS_BZ:     return {m.opcode, rs, 5'd0, imm16};
            CLS_REGIMM: return {m.opcode, rs, m.funct[4:0], imm16};
            CLS_JUMP:   return {m.opcode, imm26};
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO (module sync_fifo) buffering encoded words. Storage is
// cleared on reset so the head reads zero; flush only rewinds the pointers.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_out = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; flush wins over push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= data_in;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: assembles words from mnemonic + fields, buffers
// them in sync_fifo and streams them with a running word address.
// Optional feature macro: DELAY_SLOT_NOP_EN (insert a nop after every
// branch/jump via the PAD state).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm16,
    input  logic [25:0] in_imm26,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [7:0]  err_count
);
    logic [0:0]  state;
    logic [0:0]  state_next;
    mnem_info_t  info;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] push_word;
    logic        full;
    logic        empty;

    assign info      = mnem_info(in_op);
    assign legal     = (info.cls != CLS_ILLEGAL);
    assign in_ready  = !full && (state == ST_IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // Push selection and next state; a PAD push inserts a nop once space exists
    always_comb begin
        push       = 1'b0;
        push_word  = encode(info, in_rs, in_rt, in_rd, in_shamt, in_imm16, in_imm26);
        state_next = state;
`ifdef DELAY_SLOT_NOP_EN
        if (flush) begin
            state_next = ST_IDLE;
        end else if (state == ST_PAD) begin
            if (!full) begin
                push       = 1'b1;
                push_word  = '0;
                state_next = ST_IDLE;
            end
        end else if (accept && legal) begin
            push = 1'b1;
            if (is_cti(in_op)) state_next = ST_PAD;
        end
`else
        if (accept && legal) push = 1'b1;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Output word address: restarts on flush, advances per popped word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     out_addr <= BASE_ADDR;
        else if (flush) out_addr <= BASE_ADDR;
        else if (pop)   out_addr <= out_addr + 32'd4;
    end

    // Illegal-mnemonic pulse and saturating counter (kept across flush)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_illegal <= 1'b0;
            err_count   <= '0;
        end else begin
            err_illegal <= accept && !legal;
            if (accept && !legal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (push),
        .data_in  (push_word),
        .pop      (pop),
        .data_out (out_instr),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus random traffic
// against a table-driven reference model and an expected-word queue.
module tb_instr_encoder;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_3000;
`ifdef DELAY_SLOT_NOP_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int F_BAD = 0, F_NOP = 1, F_R = 2, F_SH = 3, F_MD = 4, F_MF = 5, F_MT = 6,
                   F_JALR = 7, F_I = 8, F_LUI = 9, F_BZ = 10, F_RI = 11, F_J = 12;
    localparam logic [5:0] OP_ADDU = 6'd2, OP_SLL = 6'd14, OP_ORI = 6'd30, OP_LUI = 6'd44,
                           OP_BEQ = 6'd42, OP_JAL = 6'd50, OP_BAD = 6'h3F;

    logic clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, err_illegal;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0] in_imm16 = '0;
    logic [25:0] in_imm26 = '0;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;

    int checks = 0, errors = 0;
    int fmt_tab[64], opc_tab[64], fn_tab[64];
    bit cti_tab[64];
    logic [31:0] q[$];
    int unsigned exp_addr;
    int exp_cnt;
    bit exp_err, pad, last_acc;

    always #5 clk = ~clk;

    instr_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm16(in_imm16), .in_imm26(in_imm26), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err_illegal(err_illegal), .err_count(err_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int op, input int f, input int o, input int fn, input bit cti);
        fmt_tab[op] = f; opc_tab[op] = o; fn_tab[op] = fn; cti_tab[op] = cti;
    endtask

    task automatic load_tables();
        for (int i = 0; i < 64; i++) set_op(i, F_BAD, 0, 0, 0);
        set_op(0, F_NOP, 0, 0, 0);
        set_op(1, F_R, 0, 32, 0);  set_op(2, F_R, 0, 33, 0);  set_op(3, F_R, 0, 34, 0);
        set_op(4, F_R, 0, 35, 0);  set_op(5, F_R, 0, 36, 0);  set_op(6, F_R, 0, 37, 0);
        set_op(7, F_R, 0, 38, 0);  set_op(8, F_R, 0, 39, 0);  set_op(9, F_R, 0, 42, 0);
        set_op(10, F_R, 0, 43, 0); set_op(11, F_R, 0, 4, 0);  set_op(12, F_R, 0, 6, 0);
        set_op(13, F_R, 0, 7, 0);
        set_op(14, F_SH, 0, 0, 0); set_op(15, F_SH, 0, 2, 0); set_op(16, F_SH, 0, 3, 0);
        set_op(17, F_MD, 0, 24, 0); set_op(18, F_MD, 0, 25, 0);
        set_op(19, F_MD, 0, 26, 0); set_op(20, F_MD, 0, 27, 0);
        set_op(21, F_MF, 0, 16, 0); set_op(22, F_MF, 0, 18, 0);
        set_op(23, F_MT, 0, 17, 0); set_op(24, F_MT, 0, 19, 0); set_op(25, F_MT, 0, 8, 1);
        set_op(26, F_JALR, 0, 9, 1);
        set_op(27, F_I, 8, 0, 0);  set_op(28, F_I, 9, 0, 0);  set_op(29, F_I, 12, 0, 0);
        set_op(30, F_I, 13, 0, 0); set_op(31, F_I, 14, 0, 0); set_op(32, F_I, 10, 0, 0);
        set_op(33, F_I, 11, 0, 0); set_op(34, F_I, 32, 0, 0); set_op(35, F_I, 36, 0, 0);
        set_op(36, F_I, 33, 0, 0); set_op(37, F_I, 37, 0, 0); set_op(38, F_I, 35, 0, 0);
        set_op(39, F_I, 40, 0, 0); set_op(40, F_I, 41, 0, 0); set_op(41, F_I, 43, 0, 0);
        set_op(42, F_I, 4, 0, 1);  set_op(43, F_I, 5, 0, 1);
        set_op(44, F_LUI, 15, 0, 0);
        set_op(45, F_BZ, 6, 0, 1); set_op(46, F_BZ, 7, 0, 1);
        set_op(47, F_RI, 1, 0, 1); set_op(48, F_RI, 1, 1, 1);
        set_op(49, F_J, 2, 0, 1);  set_op(50, F_J, 3, 0, 1);
    endtask

    // Field weights: op 2^26, rs 2^21, rt 2^16, rd 2^11, shamt 2^6
    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int i16, input int i26);
        int unsigned o, fn;
        o = opc_tab[op] * 32'd67108864; fn = fn_tab[op];
        case (fmt_tab[op])
            F_R:    return fn + rd * 2048 + rt * 65536 + rs * 2097152;
            F_SH:   return fn + sh * 64 + rd * 2048 + rt * 65536;
            F_MD:   return fn + rt * 65536 + rs * 2097152;
            F_MF:   return fn + rd * 2048;
            F_MT:   return fn + rs * 2097152;
            F_JALR: return fn + ((rd == 0) ? 31 : rd) * 2048 + rs * 2097152;
            F_I:    return o + rs * 2097152 + rt * 65536 + i16;
            F_LUI:  return o + rt * 65536 + i16;
            F_BZ:   return o + rs * 2097152 + i16;
            F_RI:   return o + rs * 2097152 + fn * 65536 + i16;
            F_J:    return o + i26;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: check DUT against model, advance model, cross the edge
    task automatic tick();
        int unsigned cnt0;
        bit rdy;
        #1;
        cnt0 = q.size();
        check_eq("err_illegal", err_illegal, exp_err);
        check_eq("err_count", err_count, exp_cnt);
        check_eq("out_valid", out_valid, cnt0 != 0);
        rdy = !flush && !pad && (cnt0 < DEPTH);
        check_eq("in_ready", in_ready, rdy);
        if (cnt0 != 0) begin
            check_eq("out_instr", out_instr, q[0]);
            check_eq("out_addr", out_addr, exp_addr);
        end
        last_acc = in_valid && rdy;
        exp_err = 1'b0;
        if (flush) begin
            q.delete(); pad = 1'b0; exp_addr = BASE;
        end else begin
            if (cnt0 != 0 && out_ready) begin
                void'(q.pop_front());
                exp_addr += 4;
            end
            if (last_acc) begin
                if (fmt_tab[in_op] == F_BAD) begin
                    exp_err = 1'b1;
                    if (exp_cnt < 255) exp_cnt++;
                end else begin
                    q.push_back(ref_word(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm16, in_imm26));
                    if (PAD_EN && cti_tab[in_op]) pad = 1'b1;
                end
            end else if (pad && cnt0 < DEPTH) begin
                q.push_back(32'd0);
                pad = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] i16,
                        input logic [25:0] i26, output int n);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm16 = i16; in_imm26 = i26; in_valid = 1'b1;
        n = 0; last_acc = 1'b0;
        while (!last_acc && n < 64) begin tick(); n++; end
        in_valid = 1'b0;
        if (!last_acc) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_flush();
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || pad) && n < 64) begin tick(); n++; end
        if (q.size() != 0 || pad) check_eq("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_addr", out_addr, BASE);
        check_eq("rst_err", err_illegal, 1'b0);
        check_eq("rst_cnt", err_count, 8'd0);
        q.delete(); pad = 1'b0; exp_addr = BASE; exp_err = 1'b0; exp_cnt = 0;
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        load_tables();
        @(negedge clk);
        do_reset();
        out_ready = 1'b1;

        send(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, n);
        #1;
        check_eq("addu_word", out_instr, 32'h00221821);
        check_eq("addu_addr", out_addr, 32'h3000);
        drain();

        do_flush();
        out_ready = 1'b0;
        send(OP_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, n);
        send(OP_LUI, 5'd7, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'd0, n);
        #1;
        check_eq("ori_word", out_instr, 32'h34011234);
        check_eq("ori_addr", out_addr, 32'h3000);
        out_ready = 1'b1;
        tick();
        #1;
        check_eq("lui_word", out_instr, 32'h3C05FFFF);
        check_eq("lui_addr", out_addr, 32'h3004);
        drain();

        do_flush();
        send(OP_SLL, 5'd7, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, n);
        #1 check_eq("sll_word", out_instr, 32'h00011100);
        drain();

        // Backpressure: four words fill the buffer, the fifth waits for a pop
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(OP_ADDU, 5'd1, 5'd2, 5'(i + 4), 5'd0, 16'd0, 26'd0, n);
        in_op = OP_ADDU; in_rd = 5'd9; in_valid = 1'b1;
        repeat (3) tick();
        out_ready = 1'b1;
        send(OP_ADDU, 5'd1, 5'd2, 5'd9, 5'd0, 16'd0, 26'd0, n);
        check_eq("fifth_wait", n, 2);
        drain();

        // Illegal mnemonic: handshake completes, nothing is queued
        do_flush();
        send(OP_BAD, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1, n);
        #1;
        check_eq("illegal_pulse", err_illegal, 1'b1);
        check_eq("illegal_cnt1", err_count, 8'd1);
        check_eq("illegal_noout", out_valid, 1'b0);
        tick();
        for (int i = 0; i < 300; i++) send(OP_BAD, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, n);
        tick();
        check_eq("illegal_sat", err_count, 8'd255);

        // Branch/jump stream, then a flush while a pad is pending
        do_flush();
        out_ready = 1'b0;
        send(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, n);
`ifdef DELAY_SLOT_NOP_EN
        #1 check_eq("pad_ready", in_ready, 1'b0);
`else
        #1 check_eq("nopad_ready", in_ready, 1'b1);
`endif
        send(OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'hC03, n);
        drain();
        out_ready = 1'b0;
        send(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, n);
        do_flush();
        check_eq("flush_valid", out_valid, 1'b0);
        send(OP_ADDU, 5'd3, 5'd4, 5'd5, 5'd0, 16'd0, 26'd0, n);
        #1 check_eq("flush_addr", out_addr, 32'h3000);
        drain();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            in_op     = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 50))
                                                   : 6'($urandom_range(51, 63));
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt = 5'($urandom); in_imm16 = 16'($urandom); in_imm26 = 26'($urandom);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        drain();

        // Reset with words in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(OP_ADDU, 5'(i), 5'd1, 5'd2, 5'd0, 16'd0, 26'd0, n);
        do_reset();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
